ladybird_axi_rd_arbiter: RTL and testbench

- Shares one AXI4 read-only master port between two read requesters: port 0 (instruction fetch) and port 1 (load path).
- Sits between the fetch/load units and the memory-side AXI interconnect.
- Only one read transaction is outstanding at a time, which matches the upstream units, since each issues one request and waits for rlast.
- Arbitration is round-robin with a registered grant. R beats are routed back to the granted requester.

---
 rtl/ladybird_axi_rd_arbiter.sv | 153 +++++++++++++++
 tb/tb_ladybird_axi_rd_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ladybird_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ladybird_axi_rd_arbiter
// Brief    : Round-robin share of one AXI4 read master port between fetch (0)
//            and load (1) requesters, one transaction outstanding at a time.
// Revision : 1.0  initial release
// ============================================================================
module ladybird_axi_rd_arbiter #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ID_W-1:0]   s0_arid,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [7:0]        s0_arlen,
  input  logic [2:0]        s0_arsize,
  input  logic [1:0]        s0_arburst,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  output logic [ID_W-1:0]   s0_rid,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,
  output logic              s0_rvalid,
  input  logic              s0_rready,

  input  logic [ID_W-1:0]   s1_arid,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [7:0]        s1_arlen,
  input  logic [2:0]        s1_arsize,
  input  logic [1:0]        s1_arburst,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [ID_W-1:0]   s1_rid,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,
  output logic              s1_rvalid,
  input  logic              s1_rready,

  output logic [ID_W-1:0]   m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [ID_W-1:0]   m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_grant_q, last_grant_d;

  logic   sel_arvalid;
  logic   sel_rready;
  logic   in_ar;
  logic   in_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign sel_arvalid = grant_q ? s1_arvalid : s0_arvalid;
  assign sel_rready  = grant_q ? s1_rready  : s0_rready;
  assign in_ar       = (state_q == ST_AR);
  assign in_r        = (state_q == ST_R);

  // Grant is only updated in IDLE, so arready never depends on arvalid
  // within the same cycle.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (s0_arvalid && s1_arvalid) begin
          grant_d = ~last_grant_q;
          state_d = ST_AR;
        end else if (s0_arvalid) begin
          grant_d = 1'b0;
          state_d = ST_AR;
        end else if (s1_arvalid) begin
          grant_d = 1'b1;
          state_d = ST_AR;
        end
      end
      ST_AR: begin
        if (m_arvalid && m_arready) begin
          state_d = ST_R;
        end
      end
      ST_R: begin
        if (m_rvalid && m_rready && m_rlast) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // AR payload is always muxed from grant so it is deterministic in reset.
  assign m_arid    = grant_q ? s1_arid    : s0_arid;
  assign m_araddr  = grant_q ? s1_araddr  : s0_araddr;
  assign m_arlen   = grant_q ? s1_arlen   : s0_arlen;
  assign m_arsize  = grant_q ? s1_arsize  : s0_arsize;
  assign m_arburst = grant_q ? s1_arburst : s0_arburst;

  assign m_arvalid  = in_ar & sel_arvalid;
  assign s0_arready = in_ar & ~grant_q & m_arready;
  assign s1_arready = in_ar &  grant_q & m_arready;

  // R payload fans out to both requesters; only rvalid qualifies the owner.
  assign s0_rid   = m_rid;
  assign s0_rdata = m_rdata;
  assign s0_rresp = m_rresp;
  assign s0_rlast = m_rlast;
  assign s1_rid   = m_rid;
  assign s1_rdata = m_rdata;
  assign s1_rresp = m_rresp;
  assign s1_rlast = m_rlast;

  assign s0_rvalid = in_r & ~grant_q & m_rvalid;
  assign s1_rvalid = in_r &  grant_q & m_rvalid;
  assign m_rready  = in_r & sel_rready;

endmodule
`default_nettype wire

// File: tb/tb_ladybird_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ladybird_axi_rd_arbiter
// Brief    : Directed bench with a scoreboard of expected R beats per port.
// Revision : 1.0  initial release
// ============================================================================
module tb_ladybird_axi_rd_arbiter;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;

  logic [ID_W-1:0]   s0_arid = '0, s1_arid = '0;
  logic [ADDR_W-1:0] s0_araddr = '0, s1_araddr = '0;
  logic [7:0]        s0_arlen = '0, s1_arlen = '0;
  logic [2:0]        s0_arsize = '0, s1_arsize = '0;
  logic [1:0]        s0_arburst = '0, s1_arburst = '0;
  logic              s0_arvalid = 1'b0, s1_arvalid = 1'b0;
  logic              s0_arready, s1_arready;
  logic [ID_W-1:0]   s0_rid, s1_rid;
  logic [DATA_W-1:0] s0_rdata, s1_rdata;
  logic [1:0]        s0_rresp, s1_rresp;
  logic              s0_rlast, s1_rlast;
  logic              s0_rvalid, s1_rvalid;
  logic              s0_rready = 1'b1, s1_rready = 1'b1;

  logic [ID_W-1:0]   m_arid;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;
  logic              m_arvalid;
  logic              m_arready;
  logic [ID_W-1:0]   m_rid = '0;
  logic [DATA_W-1:0] m_rdata = '0;
  logic [1:0]        m_rresp = '0;
  logic              m_rlast = 1'b0;
  logic              m_rvalid = 1'b0;
  logic              m_rready;

  logic              ar_hold = 1'b0;
  assign m_arready = ~ar_hold;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t             exp0[$];
  beat_t             exp1[$];
  logic [ADDR_W-1:0] ar_log[$];

  ladybird_axi_rd_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
    .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_arvalid(s0_arvalid),
    .s0_arready(s0_arready), .s0_rid(s0_rid), .s0_rdata(s0_rdata),
    .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid),
    .s0_rready(s0_rready),
    .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
    .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_arvalid(s1_arvalid),
    .s1_arready(s1_arready), .s1_rid(s1_rid), .s1_rdata(s1_rdata),
    .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid),
    .s1_rready(s1_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a, input int b);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a << 8) ^ 32'hC0DE0000 ^ DATA_W'(b);
  endfunction

  function automatic logic arvalid_of(input int p); return p == 0 ? s0_arvalid : s1_arvalid; endfunction
  function automatic logic arready_of(input int p); return p == 0 ? s0_arready : s1_arready; endfunction
  function automatic logic rvalid_of(input int p);  return p == 0 ? s0_rvalid  : s1_rvalid;  endfunction
  function automatic logic rready_of(input int p);  return p == 0 ? s0_rready  : s1_rready;  endfunction
  function automatic logic rlast_of(input int p);   return p == 0 ? s0_rlast   : s1_rlast;   endfunction

  // Memory-side slave: one burst at a time, data derived from address/beat.
  initial begin : slave
    logic              ar_hs, r_hs, rs, busy;
    logic [ID_W-1:0]   id_c, id;
    logic [ADDR_W-1:0] addr_c, addr;
    logic [7:0]        len_c, len;
    int                beat;
    busy = 1'b0; id = '0; addr = '0; len = '0; beat = 0;
    forever begin
      @(negedge clk);
      ar_hs  = m_arvalid && m_arready;
      r_hs   = m_rvalid && m_rready;
      rs     = rst;
      id_c   = m_arid;
      addr_c = m_araddr;
      len_c  = m_arlen;
      @(posedge clk);
      #1;
      if (rs) begin
        busy = 1'b0;
      end else begin
        if (r_hs) begin
          if (beat == int'(len)) busy = 1'b0;
          else beat++;
        end
        if (ar_hs) begin
          busy = 1'b1; id = id_c; addr = addr_c; len = len_c; beat = 0;
        end
      end
      m_rvalid = busy;
      m_rid    = id;
      m_rdata  = busy ? exp_data(addr, beat) : '0;
      m_rlast  = busy && (beat == int'(len));
      m_rresp  = 2'b00;
    end
  end

  task automatic check_beat(input int p);
    beat_t e;
    if (p == 0 ? exp0.size() == 0 : exp1.size() == 0) begin
      chk(p == 0 ? "s0_unexpected_beat" : "s1_unexpected_beat", rvalid_of(p), 1'b0);
      return;
    end
    e = (p == 0) ? exp0.pop_front() : exp1.pop_front();
    chk(p == 0 ? "s0_rdata" : "s1_rdata", p == 0 ? s0_rdata : s1_rdata, e.data);
    chk(p == 0 ? "s0_rid"   : "s1_rid",   p == 0 ? s0_rid   : s1_rid,   e.id);
    chk(p == 0 ? "s0_rlast" : "s1_rlast", rlast_of(p), e.last);
    chk(p == 0 ? "s0_rresp" : "s1_rresp", p == 0 ? s0_rresp : s1_rresp, 2'b00);
  endtask

  always @(negedge clk) begin
    if (m_arvalid && m_arready) ar_log.push_back(m_araddr);
    if (s0_rvalid && s0_rready) check_beat(0);
    if (s1_rvalid && s1_rready) check_beat(1);
  end

  task automatic drive_req(input int p, input logic [ID_W-1:0] id,
                           input logic [ADDR_W-1:0] addr, input logic [7:0] len);
    beat_t b;
    for (int i = 0; i <= int'(len); i++) begin
      b.id = id; b.data = exp_data(addr, i); b.last = (i == int'(len));
      if (p == 0) exp0.push_back(b); else exp1.push_back(b);
    end
    if (p == 0) begin
      s0_arid = id; s0_araddr = addr; s0_arlen = len; s0_arsize = 3'd2;
      s0_arburst = 2'b01; s0_arvalid = 1'b1;
    end else begin
      s1_arid = id; s1_araddr = addr; s1_arlen = len; s1_arsize = 3'd2;
      s1_arburst = 2'b01; s1_arvalid = 1'b1;
    end
  endtask

  // Call at a negedge; returns at posedge+1 with arvalid dropped.
  task automatic wait_ar(input int p);
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (arvalid_of(p) && arready_of(p)) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk(p == 0 ? "s0_ar_handshake" : "s1_ar_handshake", ok, 1'b1);
    @(posedge clk); #1;
    if (p == 0) s0_arvalid = 1'b0; else s1_arvalid = 1'b0;
  endtask

  // Returns at the negedge of the rlast handshake on port p.
  task automatic wait_last(input int p);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      chk("other_arready_held", arready_of(1 - p), 1'b0);
      chk("other_rvalid_held", rvalid_of(1 - p), 1'b0);
      if (rvalid_of(p) && rready_of(p) && rlast_of(p)) begin ok = 1'b1; break; end
    end
    chk(p == 0 ? "s0_rlast_seen" : "s1_rlast_seen", ok, 1'b1);
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp0.delete(); exp1.delete(); ar_log.delete();
  endtask

  task automatic run_dual(input int n0, input int n1, input logic [7:0] len, input bit tog1);
    int rem[2];
    int st[2];
    int k[2];
    bit drop[2];
    bit done = 1'b0;
    rem[0] = n0; rem[1] = n1; st[0] = 0; st[1] = 0; k[0] = 0; k[1] = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (st[p] == 0 && rem[p] > 0) begin
          drive_req(p, p == 0 ? 4'h3 : 4'hC,
                    (p == 0 ? 32'h1000 : 32'h2000) + 32'(k[p] * 'h40), len);
          k[p]++; rem[p]--; st[p] = 1;
        end
      end
      s1_rready = tog1 ? ~s1_rready : 1'b1;
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (st[p] == 2) begin
          chk("inflight_other_arready", arready_of(1 - p), 1'b0);
          chk("inflight_other_rvalid", rvalid_of(1 - p), 1'b0);
          if (tog1 && p == 1) chk("m_rready_mirror", m_rready, s1_rready);
        end
      end
      for (int p = 0; p < 2; p++) begin
        drop[p] = 1'b0;
        if (st[p] == 1 && arvalid_of(p) && arready_of(p)) begin
          st[p] = 2; drop[p] = 1'b1;
        end else if (st[p] == 2 && rvalid_of(p) && rready_of(p) && rlast_of(p)) begin
          st[p] = 0;
        end
      end
      if (rem[0] == 0 && rem[1] == 0 && st[0] == 0 && st[1] == 0) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (drop[0]) s0_arvalid = 1'b0;
      if (drop[1]) s1_arvalid = 1'b0;
    end
    chk("dual_done", done, 1'b1);
    s1_rready = 1'b1;
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    s0_araddr = 32'h11111110; s1_araddr = 32'h22222220;
    s0_arid = 4'h1; s1_arid = 4'h2;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_m_arvalid", m_arvalid, 1'b0);
    chk("rst_m_rready", m_rready, 1'b0);
    chk("rst_s0_arready", s0_arready, 1'b0);
    chk("rst_s1_arready", s1_arready, 1'b0);
    chk("rst_s0_rvalid", s0_rvalid, 1'b0);
    chk("rst_s1_rvalid", s1_rvalid, 1'b0);
    chk("rst_m_araddr", m_araddr, 32'h11111110);
    chk("rst_m_arid", m_arid, 4'h1);

    // Single fetch: one bubble cycle then AR
    @(posedge clk); #1;
    drive_req(0, 4'h5, 32'h100, 8'd0);
    @(negedge clk);
    chk("sf_bubble_m_arvalid", m_arvalid, 1'b0);
    chk("sf_bubble_s0_arready", s0_arready, 1'b0);
    @(negedge clk);
    chk("sf_m_arvalid", m_arvalid, 1'b1);
    chk("sf_m_araddr", m_araddr, 32'h100);
    chk("sf_m_arlen", m_arlen, 8'd0);
    chk("sf_m_arid", m_arid, 4'h5);
    wait_ar(0);
    wait_last(0);
    @(negedge clk);
    chk("sf_idle_m_arvalid", m_arvalid, 1'b0);
    chk("sf_idle_m_rready", m_rready, 1'b0);
    chk("sf_idle_s0_rvalid", s0_rvalid, 1'b0);
    chk("sf_sb_drained", 32'(exp0.size()), 0);

    // Simultaneous requests from reset: port 0 first
    do_reset();
    drive_req(0, 4'h6, 32'h200, 8'd0);
    drive_req(1, 4'h7, 32'h300, 8'd0);
    @(negedge clk);
    wait_ar(0);
    wait_last(0);
    @(negedge clk);
    wait_ar(1);
    wait_last(1);
    @(negedge clk);
    chk("sim_ar_count", 32'(ar_log.size()), 2);
    if (ar_log.size() >= 2) begin
      chk("sim_first_addr", ar_log[0], 32'h200);
      chk("sim_second_addr", ar_log[1], 32'h300);
    end

    // Continuous dual requests: strict alternation
    do_reset();
    run_dual(3, 3, 8'd0, 1'b0);
    @(negedge clk);
    chk("dual_ar_count", 32'(ar_log.size()), 6);
    for (int i = 0; i < 6 && i < ar_log.size(); i++) begin
      a = ((i % 2) == 0 ? 32'h1000 : 32'h2000) + 32'((i / 2) * 'h40);
      chk("dual_grant_order", ar_log[i], a);
    end
    chk("dual_sb0_drained", 32'(exp0.size()), 0);
    chk("dual_sb1_drained", 32'(exp1.size()), 0);

    // Burst with R backpressure on port 1
    ar_log.delete();
    s1_rready = 1'b0;
    run_dual(0, 1, 8'd3, 1'b1);
    @(negedge clk);
    chk("burst_idle_m_rready", m_rready, 1'b0);
    chk("burst_idle_s1_rvalid", s1_rvalid, 1'b0);
    chk("burst_sb_drained", 32'(exp1.size()), 0);
    chk("burst_ar_count", 32'(ar_log.size()), 1);

    // AR stall for 5 cycles
    @(posedge clk); #1;
    ar_hold = 1'b1;
    drive_req(0, 4'h9, 32'h400, 8'd1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_m_arvalid", m_arvalid, 1'b1);
      chk("stall_m_araddr", m_araddr, 32'h400);
      chk("stall_m_arlen", m_arlen, 8'd1);
      chk("stall_s0_arready", s0_arready, 1'b0);
    end
    @(posedge clk); #1;
    ar_hold = 1'b0;
    @(negedge clk);
    wait_ar(0);
    wait_last(0);
    @(negedge clk);
    chk("stall_sb_drained", 32'(exp0.size()), 0);

    // Reset during R phase after first beat
    drive_req(0, 4'hA, 32'h500, 8'd3);
    @(negedge clk);
    wait_ar(0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (s0_rvalid && s0_rready) begin seen = 1'b1; break; end
      end
      chk("mid_first_beat", seen, 1'b1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp0.delete(); exp1.delete(); ar_log.delete();
    @(negedge clk);
    chk("mid_rst_m_rready", m_rready, 1'b0);
    chk("mid_rst_s0_rvalid", s0_rvalid, 1'b0);
    chk("mid_rst_s1_rvalid", s1_rvalid, 1'b0);
    chk("mid_rst_m_arvalid", m_arvalid, 1'b0);
    @(posedge clk); #1;
    drive_req(0, 4'hB, 32'h600, 8'd0);
    drive_req(1, 4'hD, 32'h700, 8'd0);
    @(negedge clk);
    wait_ar(0);
    wait_last(0);
    @(negedge clk);
    wait_ar(1);
    wait_last(1);
    @(negedge clk);
    chk("mid_tie_count", 32'(ar_log.size()), 2);
    if (ar_log.size() >= 1) chk("mid_tie_first", ar_log[0], 32'h600);
    chk("final_sb0_drained", 32'(exp0.size()), 0);
    chk("final_sb1_drained", 32'(exp1.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
